// File: rtl/qs_partition_engine_if.sv
// Port bundle of the Lomuto partition engine: caller request/response plus
// both ports of the dual-port BRAM it drives.
interface qs_partition_engine_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
);
  logic          start;
  logic [AW-1:0] lo;
  logic [AW-1:0] hi;
  logic          busy;
  logic          done;
  logic [AW-1:0] pivot_idx;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta;
  logic          web;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic [DW-1:0] doutb;

  // Engine side
  modport slave (
    input  start, lo, hi, douta, doutb,
    output busy, done, pivot_idx, wea, addra, dina, web, addrb, dinb
  );

  // Caller / BRAM side
  modport master (
    output start, lo, hi, douta, doutb,
    input  busy, done, pivot_idx, wea, addra, dina, web, addrb, dinb
  );
endinterface

// File: rtl/qs_partition_engine.sv
// Lomuto partition of BRAM range [lo, hi] around pivot A[hi]; reports the
// pivot's final index with a one-cycle done pulse.
module qs_partition_engine #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  qs_partition_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIV_RD,
    S_PIV_CAP,
    S_RD,
    S_CMP,
    S_FIN_RD,
    S_FIN_WR,
    S_DONE
  } state_t;

  state_t        state;
  logic          busy;
  logic          done;
  logic [AW-1:0] pivot_idx;
  logic [AW-1:0] i;
  logic [AW-1:0] j;
  logic [AW-1:0] lo_r;
  logic [AW-1:0] hi_r;
  logic [DW-1:0] pivot;

  logic          less_c;
  logic [AW-1:0] j_inc_c;

  assign less_c  = bus.doutb < pivot;
  assign j_inc_c = j + AW'(1);

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pivot_idx = pivot_idx;

  // Sequencer and registered status; j stops at hi_r so no index wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pivot_idx <= '0;
      i         <= '0;
      j         <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      pivot     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            lo_r <= bus.lo;
            hi_r <= bus.hi;
            if (bus.lo < bus.hi) begin
              busy  <= 1'b1;
              state <= S_PIV_RD;
            end else begin
              pivot_idx <= bus.lo;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_PIV_RD: state <= S_PIV_CAP;
        S_PIV_CAP: begin
          pivot <= bus.doutb;
          i     <= lo_r;
          j     <= lo_r;
          state <= S_RD;
        end
        S_RD: state <= S_CMP;
        S_CMP: begin
          if (less_c) i <= i + AW'(1);
          j     <= j_inc_c;
          state <= (j_inc_c == hi_r) ? S_FIN_RD : S_RD;
        end
        S_FIN_RD: state <= S_FIN_WR;
        S_FIN_WR: begin
          pivot_idx <= i;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // BRAM port drive; the swap and final pivot placement never alias addresses
  always_comb begin
    bus.wea   = 1'b0;
    bus.web   = 1'b0;
    bus.addra = '0;
    bus.addrb = '0;
    bus.dina  = '0;
    bus.dinb  = '0;
    unique case (state)
      S_PIV_RD: bus.addrb = hi_r;
      S_RD: begin
        bus.addra = i;
        bus.addrb = j;
      end
      S_CMP: begin
        if (less_c && (i != j)) begin
          bus.wea   = 1'b1;
          bus.web   = 1'b1;
          bus.addra = i;
          bus.addrb = j;
          bus.dina  = bus.doutb;
          bus.dinb  = bus.douta;
        end
      end
      S_FIN_RD: bus.addra = i;
      S_FIN_WR: begin
        if (i != hi_r) begin
          bus.wea   = 1'b1;
          bus.web   = 1'b1;
          bus.addra = i;
          bus.addrb = hi_r;
          bus.dina  = pivot;
          bus.dinb  = bus.douta;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qs_partition_engine.sv
// Self-checking bench: BRAM model plus a software Lomuto reference model.
module tb_qs_partition_engine;

  localparam int unsigned AW    = 18;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          LIMIT = 200;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  qs_partition_engine_if #(.AW(AW), .DW(DW)) bus ();

  qs_partition_engine #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] exp_mem [0:DEPTH-1];

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  int unsigned   run_lo = 0;
  int unsigned   run_hi = 0;

  int wr_cyc = 0;
  int oob    = 0;
  int dual   = 0;
  int act    = 0;

  int checks = 0;
  int errors = 0;

  // Dual-port read-before-write BRAM with activity monitors
  always @(posedge clk) begin
    bus.douta <= mem[bus.addra];
    bus.doutb <= mem[bus.addrb];
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.wea) mem[bus.addra] <= bus.dina;
    if (bus.web) mem[bus.addrb] <= bus.dinb;
    if (bus.wea || bus.web) wr_cyc <= wr_cyc + 1;
    if (bus.wea && (32'(bus.addra) < run_lo || 32'(bus.addra) > run_hi)) oob <= oob + 1;
    if (bus.web && (32'(bus.addrb) < run_lo || 32'(bus.addrb) > run_hi)) oob <= oob + 1;
    if (bus.wea && bus.web && bus.addra == bus.addrb) dual <= dual + 1;
    if (bus.wea || bus.web || bus.addra != '0 || bus.addrb != '0) act <= act + 1;
  end

  task automatic put(input int unsigned a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = AW'(a);
    pl_data = d;
    exp_mem[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Reference: textbook Lomuto partition on the expected-memory image
  task automatic model_partition(input int unsigned l, input int unsigned h,
                                 output int unsigned p, output int nw);
    logic [DW-1:0] pv;
    logic [DW-1:0] t;
    int unsigned ii;
    pv = exp_mem[h];
    ii = l;
    nw = 0;
    for (int unsigned jj = l; jj < h; jj++) begin
      if (exp_mem[jj] < pv) begin
        if (ii != jj) begin
          t = exp_mem[ii]; exp_mem[ii] = exp_mem[jj]; exp_mem[jj] = t;
          nw++;
        end
        ii++;
      end
    end
    if (ii != h) begin
      t = exp_mem[ii]; exp_mem[ii] = exp_mem[h]; exp_mem[h] = t;
      nw++;
    end
    p = ii;
  endtask

  function automatic int region_errs(input int unsigned l, input int unsigned h);
    int n = 0;
    for (int unsigned a = l; a <= h; a++) if (mem[a] !== exp_mem[a]) n++;
    return n;
  endfunction

  // Issues one request and counts cycles until done (capped at LIMIT)
  task automatic run_op(input int unsigned l, input int unsigned h,
                        output int cyc, output logic [AW-1:0] pidx, output logic busy_ok);
    run_lo    = l;
    run_hi    = h;
    bus.lo    = AW'(l);
    bus.hi    = AW'(h);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < LIMIT) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1 cyc++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    pidx = bus.pivot_idx;
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    put(0, 16'd5); put(1, 16'd1); put(2, 16'd4); put(3, 16'd2); put(4, 16'd3); put(5, 16'hAAAA);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.lo    = '0;
    bus.hi    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.wea, bus.web} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: busy/done/wea/web = %b, expected 0000",
               {bus.busy, bus.done, bus.wea, bus.web});
    end
    checks++;
    if (bus.pivot_idx !== '0 || bus.addra !== '0 || bus.addrb !== '0 ||
        bus.dina !== '0 || bus.dinb !== '0) begin
      errors++;
      $display("FAIL reset_bus: pivot_idx=%0h addra=%0h addrb=%0h dina=%0h dinb=%0h, expected all 0",
               bus.pivot_idx, bus.addra, bus.addrb, bus.dina, bus.dinb);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int cyc; logic [AW-1:0] pidx; logic bok; int w0; int up; int nw;
    load_basic();
    model_partition(0, 4, up, nw);
    w0 = wr_cyc;
    run_op(0, 4, cyc, pidx, bok);
    checks++;
    if (cyc !== 13) begin errors++; $display("FAIL basic_latency: got %0d, expected 13", cyc); end
    checks++;
    if (pidx !== AW'(2) || up != 2) begin
      errors++; $display("FAIL basic_pivot: got %0d, expected 2 (model %0d)", pidx, up);
    end
    checks++;
    if (mem[0] !== 16'd1 || mem[1] !== 16'd2 || mem[2] !== 16'd3 || mem[3] !== 16'd5 ||
        mem[4] !== 16'd4 || mem[5] !== 16'hAAAA) begin
      errors++;
      $display("FAIL basic_mem: got %0d %0d %0d %0d %0d guard %0h, expected 1 2 3 5 4 guard aaaa",
               mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]);
    end
    checks++;
    if (wr_cyc - w0 != nw || !bok) begin
      errors++; $display("FAIL basic_writes: %0d write cycles busy_ok=%b, expected %0d and 1",
                         wr_cyc - w0, bok, nw);
    end
  endtask

  task automatic test_all_smaller();
    int cyc; logic [AW-1:0] pidx; logic bok; int w0;
    put(7, 16'h1234); put(8, 16'd1); put(9, 16'd2); put(10, 16'd3); put(11, 16'd9); put(12, 16'h4321);
    w0 = wr_cyc;
    run_op(8, 11, cyc, pidx, bok);
    checks++;
    if (pidx !== AW'(11)) begin errors++; $display("FAIL smaller_pivot: got %0d, expected 11", pidx); end
    checks++;
    if (wr_cyc - w0 != 0) begin errors++; $display("FAIL smaller_writes: got %0d, expected 0", wr_cyc - w0); end
    checks++;
    if (region_errs(7, 12) != 0 || cyc != 11) begin
      errors++; $display("FAIL smaller_mem: %0d bad words, latency %0d, expected 0 and 11",
                         region_errs(7, 12), cyc);
    end
  endtask

  task automatic test_all_larger();
    int cyc; logic [AW-1:0] pidx; logic bok; int w0;
    put(0, 16'd7); put(1, 16'd7); put(2, 16'd9); put(3, 16'd7); put(4, 16'h5555);
    w0 = wr_cyc;
    run_op(0, 3, cyc, pidx, bok);
    checks++;
    if (pidx !== AW'(0)) begin errors++; $display("FAIL larger_pivot: got %0d, expected 0", pidx); end
    checks++;
    if (wr_cyc - w0 != 1) begin errors++; $display("FAIL larger_writes: got %0d, expected 1", wr_cyc - w0); end
    checks++;
    if (region_errs(0, 4) != 0) begin
      errors++; $display("FAIL larger_mem: %0d bad words, expected 0", region_errs(0, 4));
    end
  endtask

  task automatic test_degenerate();
    int cyc; logic [AW-1:0] pidx; logic bok; int a0;
    a0 = act;
    run_op(5, 5, cyc, pidx, bok);
    checks++;
    if (cyc != 1 || pidx !== AW'(5) || !bok) begin
      errors++; $display("FAIL degen_eq: latency %0d pivot %0d busy_ok %b, expected 1 5 1", cyc, pidx, bok);
    end
    run_op(6, 2, cyc, pidx, bok);
    checks++;
    if (cyc != 1 || pidx !== AW'(6) || !bok) begin
      errors++; $display("FAIL degen_inv: latency %0d pivot %0d busy_ok %b, expected 1 6 1", cyc, pidx, bok);
    end
    checks++;
    if (act - a0 != 0) begin errors++; $display("FAIL degen_bram: %0d active cycles, expected 0", act - a0); end
  endtask

  task automatic test_top_range();
    int cyc; logic [AW-1:0] pidx; logic bok; int o0; int unsigned l;
    l  = DEPTH - 3;
    o0 = oob;
    put(l - 1, 16'h0F0F); put(l, 16'hFFFF); put(l + 1, 16'h0000); put(l + 2, 16'h8000);
    run_op(l, DEPTH - 1, cyc, pidx, bok);
    checks++;
    if (pidx !== AW'(DEPTH - 2) || cyc != 9) begin
      errors++; $display("FAIL top_pivot: got %0d latency %0d, expected %0d and 9", pidx, cyc, DEPTH - 2);
    end
    checks++;
    if (mem[l] !== 16'h0000 || mem[l + 1] !== 16'h8000 || mem[l + 2] !== 16'hFFFF ||
        mem[l - 1] !== 16'h0F0F || oob != o0) begin
      errors++; $display("FAIL top_mem: got %h %h %h guard %h oob %0d, expected 0000 8000 ffff guard 0f0f oob 0",
                         mem[l], mem[l + 1], mem[l + 2], mem[l - 1], oob - o0);
    end
  endtask

  task automatic test_random();
    int cyc; logic [AW-1:0] pidx; logic bok; int w0; int o0; int d0;
    int unsigned l; int unsigned h; int unsigned n; int unsigned up; int nw;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 12);
      l = $urandom_range(16, 4000);
      h = l + n;
      for (int unsigned a = l - 1; a <= h + 1; a++)
        put(a, (it % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom));
      model_partition(l, h, up, nw);
      w0 = wr_cyc; o0 = oob; d0 = dual;
      run_op(l, h, cyc, pidx, bok);
      checks++;
      if (pidx !== AW'(up) || cyc != int'(2 * n + 5) || !bok) begin
        errors++;
        $display("FAIL rand_result[%0d]: pivot %0d latency %0d busy_ok %b, expected %0d %0d 1",
                 it, pidx, cyc, bok, up, 2 * n + 5);
      end
      checks++;
      if (region_errs(l - 1, h + 1) != 0 || wr_cyc - w0 != nw || oob != o0 || dual != d0) begin
        errors++;
        $display("FAIL rand_mem[%0d]: bad %0d writes %0d oob %0d dual %0d, expected 0 %0d 0 0",
                 it, region_errs(l - 1, h + 1), wr_cyc - w0, oob - o0, dual - d0, nw);
      end
    end
  endtask

  task automatic test_protocol();
    int cyc; logic [AW-1:0] pidx; logic bok; int dones; int up; int nw;
    // Stray start while busy must not disturb the running partition
    load_basic();
    model_partition(0, 4, up, nw);
    run_lo = 0; run_hi = 4;
    bus.lo = AW'(0); bus.hi = AW'(4); bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < LIMIT) begin
      if (cyc == 3) begin bus.start = 1'b1; bus.lo = AW'(1); bus.hi = AW'(2); end
      else bus.start = 1'b0;
      @(posedge clk);
      #1 cyc++;
    end
    bus.start = 1'b0;
    pidx = bus.pivot_idx;
    @(posedge clk);
    #1;
    checks++;
    if (cyc != 13 || pidx !== AW'(2) || region_errs(0, 5) != 0) begin
      errors++; $display("FAIL busy_start: latency %0d pivot %0d bad %0d, expected 13 2 0",
                         cyc, pidx, region_errs(0, 5));
    end

    // Reset asserted during a swap cycle
    load_basic();
    run_lo = 0; run_hi = 4;
    bus.lo = AW'(0); bus.hi = AW'(4); bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (bus.wea !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: wea %b busy %b, expected 1 1", bus.wea, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.wea !== 1'b0 || bus.web !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_now: busy %b wea %b web %b done %b, expected 0 0 0 0",
                         bus.busy, bus.wea, bus.web, bus.done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++; end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midrst_idle: %0d active cycles, expected 0", dones); end

    load_basic();
    model_partition(0, 4, up, nw);
    run_op(0, 4, cyc, pidx, bok);
    checks++;
    if (cyc != 13 || pidx !== AW'(2) || region_errs(0, 5) != 0 || !bok) begin
      errors++; $display("FAIL post_rst: latency %0d pivot %0d bad %0d busy_ok %b, expected 13 2 0 1",
                         cyc, pidx, region_errs(0, 5), bok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_smaller();
    test_all_larger();
    test_degenerate();
    test_top_range();
    test_random();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qs_partition_engine.md
Name: qs_partition_engine

Overview:
- Lomuto partition engine for the quicksort datapath.
- Sits directly upstream of the dual-port BRAM and drives both of its ports (address, data in, write enable), reading back its registered outputs.
- On a start pulse it partitions the BRAM range [lo, hi] around pivot A[hi], reports the pivot's final index, and pulses done.
- The recursion/stack controller sequences calls to this engine.

Parameters:
- AW, 18, BRAM address width.
- DW, 16, data width; elements are compared as unsigned.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- lo  in  AW  first index of range, captured on start
- hi  in  AW  last index of range (pivot location), captured on start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; pivot_idx valid in the same cycle
- pivot_idx  out  AW  final pivot index; held until next done
- wea  out  1  BRAM port A write enable
- addra  out  AW  BRAM port A address
- dina  out  DW  BRAM port A write data
- douta  in  DW  BRAM port A read data, registered, 1-cycle latency, read-before-write
- web  out  1  BRAM port B write enable
- addrb  out  AW  BRAM port B address
- dinb  out  DW  BRAM port B write data
- doutb  in  DW  BRAM port B read data, registered, 1-cycle latency, read-before-write

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy=0, done=0, pivot_idx=0, wea=web=0, addra=addrb=0, dina=dinb=0. Internal i, j, pivot, lo_r, hi_r are all 0.
- BRAM timing: an address driven in cycle n yields data on dout in cycle n+1. The engine never writes the same address on both ports in the same cycle.
- States and transitions:
  - IDLE: on start=1, capture lo/hi.
    - lo<hi: go to PIV_RD.
    - lo>=hi: go to DONE with pivot_idx<=lo; no BRAM access.
    - start while not IDLE is ignored.
  - PIV_RD: addrb=hi_r. Go to PIV_CAP.
  - PIV_CAP: pivot<=doutb, i<=lo_r, j<=lo_r. Go to RD.
  - RD: addra=i, addrb=j, no writes. Go to CMP.
  - CMP: douta=A[i], doutb=A[j].
    - If doutb<pivot and i!=j: wea=web=1, addra=i with dina=doutb, addrb=j with dinb=douta (swap); i<=i+1.
    - If doutb<pivot and i==j: no write; i<=i+1.
    - Otherwise: no change to i.
    - Then j<=j+1. If j+1==hi_r go to FIN_RD, else go to RD.
  - FIN_RD: addra=i. Go to FIN_WR.
  - FIN_WR: if i!=hi_r: wea=1, addra=i, dina=pivot; web=1, addrb=hi_r, dinb=douta. If i==hi_r: no write. pivot_idx<=i. Go to DONE.
  - DONE: done=1 for exactly one cycle. Go to IDLE.
- busy: 1 in every state except IDLE, and 0 in the DONE cycle.
- Latency: with N=hi-lo>=1, done is high in the (2N+5)th cycle after the start-sampling edge. With lo>=hi, done is high in the 1st cycle after that edge.
- BRAM control:
  - wea/web/dina/dinb are combinational from state, i, j, pivot, douta and doutb. The doutb<pivot compare path is allowed.
  - Addresses are 0 in IDLE and DONE.
  - i and j never exceed hi_r; no wrap-around occurs, including hi=2^AW-1.
- Comparison is strictly less-than, so elements equal to the pivot stay on the right side.
- Post-condition:
  - A[lo..pivot_idx-1] < pivot, A[pivot_idx] = pivot, A[pivot_idx+1..hi] >= pivot.
  - The range is a permutation of the original.
  - Memory outside [lo, hi] is untouched.
- Reset mid-operation: immediate return to IDLE, write enables drop at once, no done. Range contents are undefined; the caller must restart.

Test Plan:
- Preload A[0..4]={5,1,4,2,3}; start lo=0, hi=4 -> done at cycle 13; pivot_idx=2; A[0..4]={1,2,3,5,4}.
- All-smaller range: A[8..11]={1,2,3,9}, lo=8, hi=11 -> pivot_idx=11; no writes (wea/web never high, since i==j on every swap and i==hi at the end); A unchanged.
- All-larger/equal range: A[0..3]={7,7,9,7}, lo=0, hi=3 -> pivot_idx=0; A={7,7,9,7}; exactly one final write cycle (A[0]<=7, A[3]<=7).
- Degenerate requests: lo=hi=5 -> done at cycle 1, pivot_idx=5, no BRAM activity. lo=6, hi=2 -> same timing, pivot_idx=6.
- Top-of-memory range: lo=2^AW-3, hi=2^AW-1, data {0xFFFF,0x0000,0x8000} -> pivot_idx=2^AW-2; result {0x0000,0x8000,0xFFFF}; no address wraps.
- Protocol: start pulsed during busy is ignored. rst_n low mid-loop -> busy=0, wea=web=0 immediately, no done. After release, a fresh start on {5,1,4,2,3} gives the first test's result.
